rv_dbg_busmaster: RTL and testbench
===================================

// Module: rv_dbg_busmaster
// PURPOSE
//  Serial-command bus initiator: parses byte frames from a UART receiver byte stream and
//  issues 32-bit reads/writes on the core-side memory/peripheral bus (adr/dw/we/re/rdy/dr).
//  Sits beside rv_core behind a bus mux; lets a host load dpram and poke ffff00xx peripherals.
//  Replies (ACK / read data / NAK) go out as a byte stream to a UART transmitter.
// PARAMETERS
//  TMO_CYCLES  1000000  inter-byte timeout in clk cycles; mid-frame silence aborts the frame
//  CMD_WR      8'h57    'W' write command byte
//  CMD_RD      8'h52    'R' read command byte
// PORTS
//  clk       in   1   system clock (cclk domain)
//  reset     in   1   asynchronous, active-high reset
//  rx_data   in   8   received byte
//  rx_valid  in   1   1-cycle strobe, rx_data valid; never back-pressured
//  tx_data   out  8   response byte
//  tx_valid  out  1   response byte valid; held until tx_ready
//  tx_ready  in   1   transmitter accepts tx_data when tx_valid & tx_ready
//  adr       out  32  bus address, word aligned by host (adr[1:0] passed through)
//  dw        out  32  bus write data
//  we        out  4   byte write enables; 4'hf for all writes
//  re        out  1   bus read enable
//  rdy       in   1   bus ready; access completes on the cycle re|we!=0 and rdy=1
//  dr        in   32  bus read data, valid the cycle after the completing read cycle
//  busy      out  1   1 whenever state != IDLE (bus mux / core hold)
// BEHAVIOUR
//  Reset: all outputs 0 (adr, dw, we, re, tx_data, tx_valid, busy); state IDLE; counters 0.
//  Frames: 'W' a3 a2 a1 a0 d3 d2 d1 d0 -> write, reply 8'h06.
//          'R' a3 a2 a1 a0 -> read, reply dr[31:24], dr[23:16], dr[15:8], dr[7:0].
//          Any other first byte -> reply 8'h15 (NAK), back to IDLE. Multi-byte fields MSB first.
//  FSM: IDLE -cmd byte-> ADDR (4 bytes) -W-> DATA (4 bytes) -> WR;  -R-> RD.
//   WR: we=4'hf, adr, dw driven from cycle after last byte; held until rdy=1; then we=0 -> RESP.
//   RD: re=1 held until rdy=1; next cycle RDW latches dr into shift reg -> RESP.
//   RESP: present bytes in order, tx_valid=1; advance on tx_valid&tx_ready; after last -> IDLE.
//  Bus strobes are registered outputs; re and we never asserted together; adr/dw stable while
//   a strobe is high. Exactly one bus access per frame.
//  rx_valid while in WR/RD/RDW/RESP: byte dropped (host must wait for reply).
//  Byte counter 2 bits, shift-in {reg[23:0], rx_data}; wraps 3->0 on field completion.
//  Timeout: counter cleared on every rx_valid and in IDLE/WR/RD/RDW/RESP; in ADDR/DATA reaching
//   TMO_CYCLES-1 -> IDLE silently (no reply, no bus access). Width $clog2(TMO_CYCLES).
//  Simultaneous rx_valid and timeout terminal count: byte wins, counter clears.
//  rdy held 0 indefinitely: stays in WR/RD (no bus timeout).
//  reset mid-access: strobes drop asynchronously, partial frame discarded.
// STRUCTURE
//  Byte codes (CMD_WR/CMD_RD/ACK 8'h06/NAK 8'h15) and state enum -> rv_dbg_pkg; u8_t/u32_t from
//   rv_types.svh.
//  One sub-module: rv_dbg_txser (loads 1 or 4 bytes, emits tx_valid/tx_ready stream, done pulse).
// TESTING
//  1) W 0x00000010 0xdeadbeef, rdy=1 -> one cycle we=4'hf adr=0x10 dw=0xdeadbeef; tx 8'h06.
//  2) R 0x00000010, rdy low 3 cycles, dr=0xdeadbeef after -> re held 4 cycles; tx de ad be ef.
//  3) First byte 8'h41 -> tx 8'h15 only, no re/we; next valid 'R' frame served normally.
//  4) 'W' + 2 addr bytes then idle TMO_CYCLES -> IDLE, busy=0, no reply, no bus strobe.
//  5) tx_ready toggled 1-of-3 during read reply -> 4 bytes in order, tx_data stable while stalled.
//  6) Assert reset during RD with re=1 -> re=0, busy=0 immediately; post-reset frame works.

Source files
------------

// File: rtl/rv_dbg_pkg.sv
// Shared byte codes, word types and FSM state encoding for the debug bus initiator.
// Other files pick these up with import rv_dbg_pkg::*.
package rv_dbg_pkg;

    typedef logic [7:0]  u8_t;
    typedef logic [31:0] u32_t;

    localparam u8_t BYTE_WR  = 8'h57;
    localparam u8_t BYTE_RD  = 8'h52;
    localparam u8_t BYTE_ACK = 8'h06;
    localparam u8_t BYTE_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rv_dbg_txser.sv
// Reply serializer: loads one byte (in the top lane) or a full word and streams it out MSB first.
// The done output pulses on the handshake of the final byte.
module rv_dbg_txser
    import rv_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        quad,
    input  logic [31:0] word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    u32_t       data_reg;
    u32_t       data_shift;
    logic [2:0] left_reg;
    logic       accept;

    assign tx_valid = (left_reg != 3'd0);
    assign tx_data  = data_reg[31:24];
    assign accept   = tx_valid && tx_ready;
    assign done     = accept && (left_reg == 3'd1);

    // Each lane takes the one below it; the bottom lane fills with zero so tx_data idles at 0.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi == 0) begin : g_bottom
                assign data_shift[7:0] = 8'h00;
            end else begin : g_upper
                assign data_shift[gi*8 +: 8] = data_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            left_reg <= 3'd0;
        end else if (load) begin
            data_reg <= word;
            left_reg <= quad ? 3'd4 : 3'd1;
        end else if (accept) begin
            data_reg <= data_shift;
            left_reg <= left_reg - 3'd1;
        end
    end

endmodule

// File: rtl/rv_dbg_busmaster.sv
// Serial-command bus initiator: byte frames in, one 32-bit read or write on the core bus,
// ACK / read data / NAK bytes out.
module rv_dbg_busmaster
    import rv_dbg_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 1000000,
    parameter logic [7:0]  CMD_WR     = BYTE_WR,
    parameter logic [7:0]  CMD_RD     = BYTE_RD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] adr,
    output logic [31:0] dw,
    output logic [3:0]  we,
    output logic        re,
    input  logic        rdy,
    input  logic [31:0] dr,
    output logic        busy
);

    localparam int TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;

    state_t           state_reg, state_next;
    logic [1:0]       cnt_reg;
    u32_t             shift_reg;
    u32_t             assembled;
    logic             cmd_wr_reg;
    u32_t             adr_reg;
    u32_t             dw_reg;
    logic [3:0]       we_reg;
    logic             re_reg;
    logic [TMO_W-1:0] tmo_reg;

    logic             field_done;
    logic             in_frame;
    logic             tmo_hit;
    logic             tx_load;
    logic             tx_quad;
    u32_t             tx_word;
    logic             tx_done;

    assign assembled  = {shift_reg[23:0], rx_data};
    assign field_done = rx_valid && (cnt_reg == 2'd3);
    assign in_frame   = (state_reg == ST_ADDR) || (state_reg == ST_DATA);
    // A byte arriving on the terminal count keeps the frame alive.
    assign tmo_hit    = (tmo_reg == TMO_LAST) && !rx_valid;

    assign adr  = adr_reg;
    assign dw   = dw_reg;
    assign we   = we_reg;
    assign re   = re_reg;
    assign busy = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        tx_load    = 1'b0;
        tx_quad    = 1'b0;
        tx_word    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_next = ST_ADDR;
                    end else begin
                        tx_load    = 1'b1;
                        tx_word    = {BYTE_NAK, 24'h0};
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (field_done)   state_next = cmd_wr_reg ? ST_DATA : ST_RD;
                else if (tmo_hit) state_next = ST_IDLE;
            end
            ST_DATA: begin
                if (field_done)   state_next = ST_WR;
                else if (tmo_hit) state_next = ST_IDLE;
            end
            ST_WR: begin
                if (rdy) begin
                    tx_load    = 1'b1;
                    tx_word    = {BYTE_ACK, 24'h0};
                    state_next = ST_RESP;
                end
            end
            ST_RD: begin
                if (rdy) state_next = ST_RDW;
            end
            ST_RDW: begin
                tx_load    = 1'b1;
                tx_quad    = 1'b1;
                tx_word    = dr;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (tx_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 2'd0;
            shift_reg  <= '0;
            cmd_wr_reg <= 1'b0;
            adr_reg    <= '0;
            dw_reg     <= '0;
            we_reg     <= 4'h0;
            re_reg     <= 1'b0;
            tmo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= 2'd0;
                    if (rx_valid) cmd_wr_reg <= (rx_data == CMD_WR);
                end
                ST_ADDR, ST_DATA: begin
                    if (rx_valid) begin
                        shift_reg <= assembled;
                        cnt_reg   <= cnt_reg + 2'd1;
                    end else if (tmo_hit) begin
                        cnt_reg <= 2'd0;
                    end
                    // Strobes launch on the edge that takes the last byte of the frame.
                    if (field_done && state_reg == ST_ADDR) begin
                        adr_reg <= assembled;
                        if (!cmd_wr_reg) re_reg <= 1'b1;
                    end
                    if (field_done && state_reg == ST_DATA) begin
                        dw_reg <= assembled;
                        we_reg <= 4'hf;
                    end
                end
                ST_WR: if (rdy) we_reg <= 4'h0;
                ST_RD: if (rdy) re_reg <= 1'b0;
                default: ;
            endcase

            if (rx_valid || !in_frame || tmo_reg == TMO_LAST) tmo_reg <= '0;
            else                                               tmo_reg <= tmo_reg + TMO_ONE;
        end
    end

    rv_dbg_txser u_txser (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .quad     (tx_quad),
        .word     (tx_word),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_rv_dbg_busmaster.sv
// Scoreboard bench for rv_dbg_busmaster: stimulus pushes expected bus accesses and reply bytes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rv_dbg_busmaster;
    import rv_dbg_pkg::*;

    localparam int TMO = 64;

    typedef struct {
        bit          is_wr;
        logic [31:0] adr;
        logic [31:0] dw;
        int          cycles;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] adr;
    logic [31:0] dw;
    logic [3:0]  we;
    logic        re;
    logic        rdy = 1'b1;
    logic [31:0] dr = 32'h0;
    logic        busy;

    logic [31:0] rd_value = 32'h0;
    logic        dr_hit;
    int          rdy_mode = 0;
    int          tx_phase = 0;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    bus_t        cur;
    int          strobe_cyc = 0;
    bit          overlap = 1'b0;
    bit          stalled = 1'b0;
    logic [7:0]  last_tx = 8'h00;

    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    rv_dbg_busmaster #(.TMO_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .adr      (adr),
        .dw       (dw),
        .we       (we),
        .re       (re),
        .rdy      (rdy),
        .dr       (dr),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Transmitter: always ready, or ready one cycle in three.
    always @(posedge clk) begin
        #1;
        tx_phase = (tx_phase + 1) % 3;
        tx_ready = (rdy_mode == 0) || (tx_phase == 0);
    end

    // Bus slave: read data appears only the cycle after the completing read cycle.
    always @(posedge clk) begin
        dr_hit = re && rdy;
        #1;
        dr = dr_hit ? rd_value : 32'h0;
    end

    always @(negedge clk) begin
        if (reset) begin
            strobe_cyc = 0;
            stalled    = 1'b0;
        end else begin
            if (re && we != 4'h0) overlap = 1'b1;
            if (stalled) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(last_tx));
            end
            stalled = tx_valid && !tx_ready;
            last_tx = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_unexpected: got %h required no byte", tx_data);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
            end
            if (re || we != 4'h0) begin
                strobe_cyc++;
                if (rdy) begin
                    if (exp_bus.size() == 0) begin
                        n_total++;
                        $display("FAIL bus_unexpected: got re=%b we=%h adr=%h required no access", re, we, adr);
                    end else begin
                        cur = exp_bus.pop_front();
                        check("bus_strobes", 32'({re, we}), cur.is_wr ? 32'h0f : 32'h10);
                        check("bus_adr", adr, cur.adr);
                        if (cur.is_wr) check("bus_dw", dw, cur.dw);
                        check("bus_cycles", 32'(strobe_cyc), 32'(cur.cycles));
                    end
                    strobe_cyc = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_bytes(input logic [7:0] cmd, input logic [31:0] a);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    endtask

    task automatic send_word(input logic [31:0] d);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic push_word(input logic [31:0] d);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < 500), 32'd1);
    endtask

    task automatic wait_re();
        int n;
        n = 0;
        while (!re && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("re_rise", 32'(re), 32'd1);
    endtask

    initial begin
        bus_t e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_adr", adr, 32'h0);
        check("rst_dw", dw, 32'h0);
        check("rst_strobes", 32'({re, we}), 32'h0);
        check("rst_tx", 32'({tx_valid, tx_data}), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write, rdy high: one-cycle strobe, ACK.
        e = '{is_wr: 1'b1, adr: 32'h10, dw: 32'hdeadbeef, cycles: 1};
        exp_bus.push_back(e);
        exp_tx.push_back(BYTE_ACK);
        send_bytes(8'h57, 32'h00000010);
        check("busy_mid_frame", 32'(busy), 32'd1);
        send_word(32'hdeadbeef);
        wait_idle("idle_after_write");

        // Read with rdy low for three cycles: re held four cycles.
        rdy = 1'b0;
        rd_value = 32'hdeadbeef;
        e = '{is_wr: 1'b0, adr: 32'h10, dw: 32'h0, cycles: 4};
        exp_bus.push_back(e);
        push_word(32'hdeadbeef);
        send_bytes(8'h52, 32'h00000010);
        wait_re();
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b1;
        wait_idle("idle_after_slow_read");

        // Unknown command: NAK only, then a normal read.
        exp_tx.push_back(BYTE_NAK);
        send_byte(8'h41);
        wait_idle("idle_after_nak");
        rd_value = 32'h12345678;
        e = '{is_wr: 1'b0, adr: 32'hffff0004, dw: 32'h0, cycles: 1};
        exp_bus.push_back(e);
        push_word(32'h12345678);
        send_bytes(8'h52, 32'hffff0004);
        wait_idle("idle_after_read");

        // Silence mid-address: abort exactly TMO cycles after the last byte.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_before_terminal", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("tmo_expired_idle", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("tmo_no_reply", 32'(tx_valid), 32'd0);

        // Byte landing on the terminal count keeps the frame.
        e = '{is_wr: 1'b1, adr: 32'h00000100, dw: 32'h11223344, cycles: 1};
        exp_bus.push_back(e);
        exp_tx.push_back(BYTE_ACK);
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (TMO - 1) @(posedge clk);
        #1;
        send_byte(8'h01);
        check("tmo_byte_wins", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_word(32'h11223344);
        wait_idle("idle_after_tmo_race");

        // Read reply with a stalling transmitter.
        rdy_mode = 1;
        rd_value = 32'hcafef00d;
        e = '{is_wr: 1'b0, adr: 32'h20, dw: 32'h0, cycles: 1};
        exp_bus.push_back(e);
        push_word(32'hcafef00d);
        send_bytes(8'h52, 32'h00000020);
        wait_idle("idle_after_stalled_reply");
        rdy_mode = 0;

        // Reset during a pending read.
        rdy = 1'b0;
        send_bytes(8'h52, 32'h00000030);
        wait_re();
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_re", 32'(re), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy = 1'b1;
        rd_value = 32'h0badf00d;
        e = '{is_wr: 1'b0, adr: 32'h40, dw: 32'h0, cycles: 1};
        exp_bus.push_back(e);
        push_word(32'h0badf00d);
        send_bytes(8'h52, 32'h00000040);
        wait_idle("idle_after_reset_frame");

        repeat (5) @(posedge clk);
        #1;
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("re_we_exclusive", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
